// File: rtl/stopwatch_lap.sv
// stopwatch_lap: parametrised BCD stopwatch with prescaler, lap freeze and sticky overflow.
// Latency: live updates on the edge that ends a tick cycle; the lap freeze is visible one clock after lap is sampled high.
// Backpressure: none; run=0 pauses the count and holds both the sub-tick phase and the digits.
// Optional feature macro: STOPWATCH_LAP_EN builds the lap state machine. When it is undefined, lap is ignored.
module stopwatch_lap #(
    parameter int                    NUM_DIGITS = 4,
    parameter int                    CLK_HZ     = 100_000_000,
    parameter int                    TICK_HZ    = 100,
    parameter logic [NUM_DIGITS-1:0] MOD6_MASK  = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    run,
    input  logic                    clear,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] live,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic                    lap_valid,
    output logic                    tick,
    output logic                    overflow
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    // Refuse to build a prescaler that cannot hit the tick rate exactly.
    generate
        if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0 || NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_param_check
            $error("stopwatch_lap: illegal NUM_DIGITS/CLK_HZ/TICK_HZ combination");
        end
    endgenerate

    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [4*NUM_DIGITS-1:0] live_q, live_d;
    logic                    overflow_q, overflow_d;
    logic                    carry;
    logic                    wrap;
    logic [3:0]              dig;
    logic [3:0]              dmax;

    // The tick strobe fires on the last prescaler phase while running. Clear suppresses it.
    always_comb begin
        tick = run & ~clear & (pre_q == PRE_MAX);
    end

    // The prescaler advances only while running, so a pause keeps the sub-tick phase.
    always_comb begin
        pre_d = pre_q;
        if (clear) begin
            pre_d = '0;
        end else if (tick) begin
            pre_d = '0;
        end else if (run) begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Ripple the tick through the digits. A carry out of the top digit means all digits were at their max.
    always_comb begin
        live_d = live_q;
        carry  = tick;
        dig    = 4'd0;
        dmax   = 4'd9;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig  = live_q[4*i +: 4];
            dmax = MOD6_MASK[i] ? 4'd5 : 4'd9;
            if (carry) begin
                if (dig >= dmax) begin
                    live_d[4*i +: 4] = 4'd0;
                end else begin
                    live_d[4*i +: 4] = dig + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        wrap       = carry;
        overflow_d = overflow_q | wrap;
        if (clear) begin
            live_d     = '0;
            overflow_d = 1'b0;
        end
    end

    // Count state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q      <= '0;
            live_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            live_q     <= live_d;
            overflow_q <= overflow_d;
        end
    end

    assign live     = live_q;
    assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
    typedef enum logic {ST_LIVE = 1'b0, ST_FROZEN = 1'b1} lap_state_t;

    lap_state_t              state_q;
    logic                    lap_q;
    logic                    lap_valid_q;
    logic [4*NUM_DIGITS-1:0] lap_reg_q;
    logic                    lap_edge;

    assign lap_edge = lap & ~lap_q;

    // The lap FSM toggles LIVE/FROZEN on each lap rising edge. Clear wins and returns it to LIVE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LIVE;
            lap_q       <= 1'b0;
            lap_valid_q <= 1'b0;
            lap_reg_q   <= '0;
        end else begin
            lap_q <= lap;
            if (clear) begin
                state_q     <= ST_LIVE;
                lap_valid_q <= 1'b0;
                lap_reg_q   <= '0;
            end else if (lap_edge) begin
                case (state_q)
                    ST_LIVE: begin
                        state_q     <= ST_FROZEN;
                        lap_valid_q <= 1'b1;
                        lap_reg_q   <= live_q;
                    end
                    default: begin
                        state_q     <= ST_LIVE;
                        lap_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign lap_valid  = lap_valid_q;
    assign digits_out = lap_valid_q ? lap_reg_q : live_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_valid  = 1'b0;
    assign digits_out = live_q;
`endif

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap: prescaler, pause, digit carry, overflow, mod-6 digit and lap freeze.
// Three instances are used: DIV=10 for the main scenarios, and DIV=2 variants so that full wraps stay short.
// Inputs are driven 1 time unit after a rising edge, and outputs are sampled there as well.
module tb_stopwatch_lap;

    logic clk = 1'b0;
    logic reset_n, clear, lap;
    logic run_m, run_f, run_6;

    logic [15:0] live_m, dout_m, live_f, dout_f, live_6, dout_6;
    logic        lv_m, tick_m, ovf_m, lv_f, tick_f, ovf_f, lv_6, tick_6, ovf_6;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stopwatch_lap #(.NUM_DIGITS(4), .CLK_HZ(1000), .TICK_HZ(100), .MOD6_MASK(4'b0000)) u_main (
        .clk(clk), .reset_n(reset_n), .run(run_m), .clear(clear), .lap(lap),
        .live(live_m), .digits_out(dout_m), .lap_valid(lv_m), .tick(tick_m), .overflow(ovf_m));

    stopwatch_lap #(.NUM_DIGITS(4), .CLK_HZ(200), .TICK_HZ(100), .MOD6_MASK(4'b0000)) u_fast (
        .clk(clk), .reset_n(reset_n), .run(run_f), .clear(clear), .lap(lap),
        .live(live_f), .digits_out(dout_f), .lap_valid(lv_f), .tick(tick_f), .overflow(ovf_f));

    stopwatch_lap #(.NUM_DIGITS(4), .CLK_HZ(200), .TICK_HZ(100), .MOD6_MASK(4'b1000)) u_m6 (
        .clk(clk), .reset_n(reset_n), .run(run_6), .clear(clear), .lap(lap),
        .live(live_6), .digits_out(dout_6), .lap_valid(lv_6), .tick(tick_6), .overflow(ovf_6));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        n_cmp++; if (live_m !== 16'h0000) begin n_bad++; $display("FAIL reset_live got=%h want=0000", live_m); end
        n_cmp++; if (dout_m !== 16'h0000) begin n_bad++; $display("FAIL reset_dout got=%h want=0000", dout_m); end
        n_cmp++; if (lv_m !== 1'b0) begin n_bad++; $display("FAIL reset_lap_valid got=%b want=0", lv_m); end
        n_cmp++; if (tick_m !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%b want=0", tick_m); end
        n_cmp++; if (ovf_m !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b want=0", ovf_m); end
        reset_n = 1'b1;
    endtask

    task automatic test_count();
        int nt;
        int first;
        nt    = 0;
        first = 0;
        run_m = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            if (tick_m === 1'b1) begin
                nt++;
                if (first == 0) first = c;
            end
            step(1);
        end
        run_m = 1'b0;
        n_cmp++; if (live_m !== 16'h0010) begin n_bad++; $display("FAIL count_live got=%h want=0010", live_m); end
        n_cmp++; if (dout_m !== 16'h0010) begin n_bad++; $display("FAIL count_dout got=%h want=0010", dout_m); end
        n_cmp++; if (nt !== 10) begin n_bad++; $display("FAIL count_ticks got=%0d want=10", nt); end
        n_cmp++; if (first !== 10) begin n_bad++; $display("FAIL count_first_tick got=%0d want=10", first); end
        n_cmp++; if (ovf_m !== 1'b0) begin n_bad++; $display("FAIL count_overflow got=%b want=0", ovf_m); end
    endtask

    task automatic test_pause();
        do_clear();
        n_cmp++; if (live_m !== 16'h0000) begin n_bad++; $display("FAIL clear_live got=%h want=0000", live_m); end
        run_m = 1'b1;
        step(35);
        run_m = 1'b0;
        step(50);
        n_cmp++; if (live_m !== 16'h0003) begin n_bad++; $display("FAIL pause_hold got=%h want=0003", live_m); end
        run_m = 1'b1;
        step(5);
        run_m = 1'b0;
        n_cmp++; if (live_m !== 16'h0004) begin n_bad++; $display("FAIL pause_resume got=%h want=0004", live_m); end
    endtask

    task automatic test_run_fall();
        do_clear();
        run_m = 1'b1;
        step(9);
        n_cmp++; if (tick_m !== 1'b1) begin n_bad++; $display("FAIL runfall_tick_before got=%b want=1", tick_m); end
        run_m = 1'b0;
        #1;
        n_cmp++; if (tick_m !== 1'b0) begin n_bad++; $display("FAIL runfall_no_tick got=%b want=0", tick_m); end
        step(3);
        n_cmp++; if (live_m !== 16'h0000) begin n_bad++; $display("FAIL runfall_live_held got=%h want=0000", live_m); end
        run_m = 1'b1;
        #1;
        n_cmp++; if (tick_m !== 1'b1) begin n_bad++; $display("FAIL runfall_tick_resume got=%b want=1", tick_m); end
        step(1);
        run_m = 1'b0;
        n_cmp++; if (live_m !== 16'h0001) begin n_bad++; $display("FAIL runfall_live got=%h want=0001", live_m); end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        do_clear();
        run_m = 1'b1;
        step(120);
        n_cmp++; if (live_m !== 16'h0012) begin n_bad++; $display("FAIL lap_pre_live got=%h want=0012", live_m); end
        lap = 1'b1;
        #1;
        n_cmp++; if (lv_m !== 1'b0) begin n_bad++; $display("FAIL lap_no_comb_path got=%b want=0", lv_m); end
        step(1);
        n_cmp++; if (dout_m !== 16'h0012) begin n_bad++; $display("FAIL lap_frozen_dout got=%h want=0012", dout_m); end
        n_cmp++; if (lv_m !== 1'b1) begin n_bad++; $display("FAIL lap_valid_set got=%b want=1", lv_m); end
        step(29);
        n_cmp++; if (live_m !== 16'h0015) begin n_bad++; $display("FAIL lap_live_runs got=%h want=0015", live_m); end
        n_cmp++; if (dout_m !== 16'h0012) begin n_bad++; $display("FAIL lap_dout_held got=%h want=0012", dout_m); end
        lap = 1'b0;
        step(1);
        lap = 1'b1;
        step(1);
        n_cmp++; if (lv_m !== 1'b0) begin n_bad++; $display("FAIL lap_unfreeze_valid got=%b want=0", lv_m); end
        n_cmp++; if (dout_m !== 16'h0015) begin n_bad++; $display("FAIL lap_unfreeze_dout got=%h want=0015", dout_m); end
        run_m = 1'b0;
    endtask

    task automatic test_lap_tick_and_clear();
        lap = 1'b0;
        step(1);
        do_clear();
        run_m = 1'b1;
        step(9);
        lap = 1'b1;
        step(1);
        n_cmp++; if (live_m !== 16'h0001) begin n_bad++; $display("FAIL laptick_live got=%h want=0001", live_m); end
        n_cmp++; if (dout_m !== 16'h0000) begin n_bad++; $display("FAIL laptick_captured got=%h want=0000", dout_m); end
        n_cmp++; if (lv_m !== 1'b1) begin n_bad++; $display("FAIL laptick_valid got=%b want=1", lv_m); end
        step(9);
        clear = 1'b1;
        #1;
        n_cmp++; if (tick_m !== 1'b0) begin n_bad++; $display("FAIL clrfrozen_tick got=%b want=0", tick_m); end
        step(1);
        clear = 1'b0;
        run_m = 1'b0;
        lap   = 1'b0;
        n_cmp++; if (live_m !== 16'h0000) begin n_bad++; $display("FAIL clrfrozen_live got=%h want=0000", live_m); end
        n_cmp++; if (dout_m !== 16'h0000) begin n_bad++; $display("FAIL clrfrozen_dout got=%h want=0000", dout_m); end
        n_cmp++; if (lv_m !== 1'b0) begin n_bad++; $display("FAIL clrfrozen_valid got=%b want=0", lv_m); end
    endtask
`else
    task automatic test_lap_disabled();
        do_clear();
        run_m = 1'b1;
        step(20);
        lap = 1'b1;
        step(1);
        n_cmp++; if (lv_m !== 1'b0) begin n_bad++; $display("FAIL lapoff_valid got=%b want=0", lv_m); end
        n_cmp++; if (live_m !== 16'h0002) begin n_bad++; $display("FAIL lapoff_live got=%h want=0002", live_m); end
        n_cmp++; if (dout_m !== 16'h0002) begin n_bad++; $display("FAIL lapoff_dout got=%h want=0002", dout_m); end
        lap   = 1'b0;
        run_m = 1'b0;
    endtask
`endif

    task automatic test_overflow();
        do_clear();
        run_f = 1'b1;
        step(19998);
        n_cmp++; if (live_f !== 16'h9999) begin n_bad++; $display("FAIL ovf_at_max got=%h want=9999", live_f); end
        n_cmp++; if (ovf_f !== 1'b0) begin n_bad++; $display("FAIL ovf_not_yet got=%b want=0", ovf_f); end
        step(2);
        n_cmp++; if (live_f !== 16'h0000) begin n_bad++; $display("FAIL ovf_wrap_live got=%h want=0000", live_f); end
        n_cmp++; if (ovf_f !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b want=1", ovf_f); end
        step(10);
        n_cmp++; if (ovf_f !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b want=1", ovf_f); end
        n_cmp++; if (live_f !== 16'h0005) begin n_bad++; $display("FAIL ovf_after_wrap got=%h want=0005", live_f); end
        run_f = 1'b0;
        do_clear();
        n_cmp++; if (ovf_f !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared got=%b want=0", ovf_f); end
    endtask

    task automatic test_mod6();
        do_clear();
        run_6 = 1'b1;
        step(1918);
        n_cmp++; if (live_6 !== 16'h0959) begin n_bad++; $display("FAIL mod6_reach got=%h want=0959", live_6); end
        step(2);
        n_cmp++; if (live_6 !== 16'h0960) begin n_bad++; $display("FAIL mod6_digit2_mod10 got=%h want=0960", live_6); end
        step(10078);
        n_cmp++; if (live_6 !== 16'h5999) begin n_bad++; $display("FAIL mod6_max got=%h want=5999", live_6); end
        n_cmp++; if (ovf_6 !== 1'b0) begin n_bad++; $display("FAIL mod6_no_ovf got=%b want=0", ovf_6); end
        step(2);
        n_cmp++; if (live_6 !== 16'h0000) begin n_bad++; $display("FAIL mod6_wrap got=%h want=0000", live_6); end
        n_cmp++; if (ovf_6 !== 1'b1) begin n_bad++; $display("FAIL mod6_ovf got=%b want=1", ovf_6); end
        run_6 = 1'b0;
    endtask

    task automatic test_async_reset();
        run_m = 1'b1;
        step(37);
        n_cmp++; if (live_m !== 16'h0003) begin n_bad++; $display("FAIL arst_pre_live got=%h want=0003", live_m); end
        reset_n = 1'b0;
        #2;
        n_cmp++; if (live_m !== 16'h0000) begin n_bad++; $display("FAIL arst_live got=%h want=0000", live_m); end
        n_cmp++; if (dout_m !== 16'h0000) begin n_bad++; $display("FAIL arst_dout got=%h want=0000", dout_m); end
        n_cmp++; if (ovf_6 !== 1'b0) begin n_bad++; $display("FAIL arst_overflow got=%b want=0", ovf_6); end
        n_cmp++; if (tick_m !== 1'b0) begin n_bad++; $display("FAIL arst_tick got=%b want=0", tick_m); end
        run_m = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        lap     = 1'b0;
        run_m   = 1'b0;
        run_f   = 1'b0;
        run_6   = 1'b0;
        test_reset();
        test_count();
        test_pause();
        test_run_fall();
`ifdef STOPWATCH_LAP_EN
        test_lap();
        test_lap_tick_and_clear();
`else
        test_lap_disabled();
`endif
        test_overflow();
        test_mod6();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
